ng_stats_ctrl: RTL and testbench
================================

NG_STATS_CTRL -- requirements
Module: ng_stats_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 11, meaning signed sample width.
REQ-002 SHALL have parameter LEN_W, default 16, meaning window-length field width.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port nreset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to begin one measurement window.
REQ-006 SHALL have port abort, input, 1, cancel the measurement in progress.
REQ-007 SHALL have port cfg_len, input, LEN_W, number of samples in the window, sampled at accepted start.
REQ-008 SHALL have port sample_valid, input, 1, sample qualifier.
REQ-009 SHALL have port sample, input, SAMPLE_W signed, noise-generator sample.
REQ-010 SHALL have port busy, output, 1, high from accepted start until done or abort.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when results update.
REQ-012 SHALL have port err, output, 1, one-cycle pulse when a start is rejected.
REQ-013 SHALL have port result_valid, output, 1, high from done until the next accepted start or abort.
REQ-014 SHALL have port mean, output, SAMPLE_W signed, window mean.
REQ-015 SHALL have port var, output, 2*SAMPLE_W unsigned, window variance.

Function
REQ-016 SHALL implement states IDLE, ACC, DIV_MEAN, DIV_SQ, FINISH.
REQ-017 IDLE: start=1, abort=0, busy=0, cfg_len!=0 -> clear sum and sumsq, latch cfg_len, clear the sample counter, clear result_valid, go to ACC.
REQ-018 IDLE: start with cfg_len=0 -> err=1 for one cycle, stay IDLE, outputs unchanged.
REQ-019 ACC: each cycle with sample_valid=1 -> sum += sample (27-bit signed), sumsq += sample*sample (38-bit unsigned), count += 1.
REQ-020 ACC: when the accepted sample makes count equal the latched length -> go to DIV_MEAN.
REQ-021 sample_valid SHALL be ignored outside ACC.
REQ-022 DIV_MEAN: divide |sum|, zero-extended to 38 bits, by the latched length.
REQ-023 mean SHALL be truncated toward zero, then negated if sum<0.
REQ-024 DIV_SQ: divide sumsq by the latched length, giving msq.
REQ-025 var SHALL equal msq - mean*mean, clamped to 0 if negative.
REQ-026 Each division SHALL take exactly 38 cycles, one quotient bit per cycle.
REQ-027 done SHALL pulse exactly 78 cycles after the clock edge that accepts the final sample; mean, var and result_valid SHALL update on that same edge; FSM returns to IDLE.
REQ-028 mean and var SHALL hold between windows.
REQ-029 start while busy SHALL be ignored, with no err.
REQ-030 abort in any non-IDLE state -> IDLE on next edge; no done; result_valid=0; mean and var retained.
REQ-031 abort and start in the same IDLE cycle: abort wins, start ignored.

Reset
REQ-032 nreset=0 SHALL force, asynchronously: IDLE, busy=0, done=0, err=0, result_valid=0, mean=0, var=0, accumulators=0, counter=0.
REQ-033 Reset mid-window SHALL discard the window with no done pulse.

Structure
REQ-034 Package ng_pkg SHALL hold SAMPLE_W, LEN_W, SUM_W=27, SQ_W=38, DIV_CYCLES=38 and the state enum.
REQ-035 Division SHALL be in sub-module ng_serial_div: unsigned restoring divider, 38-bit dividend, 16-bit divisor, start/busy/done handshake, one instance shared by both divide states.

Verification
REQ-036 len=4, samples 1,2,3,4 -> mean=2, var=3 (30/4=7, 7-4), done 78 cycles after the 4th sample.
REQ-037 len=3, samples -5,-5,-6 with sample_valid gaps -> mean=-5, var=3 (86/3=28, 28-25).
REQ-038 len=1, sample -1024 -> mean=-1024, var=0; start=1 with len=0 -> err pulse, busy stays 0.
REQ-039 abort after 2 of 5 samples, then start len=2, samples 7,9 -> no done for the aborted window; then mean=8, var=1.
REQ-040 start pulses during DIV_MEAN -> ignored, no err, single done; nreset asserted in ACC -> all outputs 0 immediately.

Source files
------------

// File: rtl/ng_pkg.sv
// Shared widths and FSM state encoding for the noise-generator statistics block.
package ng_pkg;

    localparam int unsigned SAMPLE_W   = 11;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned SUM_W      = 27;
    localparam int unsigned SQ_W       = 38;
    localparam int unsigned DIV_CYCLES = 38;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        DIV_MEAN,
        DIV_SQ,
        FINISH
    } state_t;

endpackage

// File: rtl/ng_serial_div.sv
// Unsigned restoring divider, one quotient bit per cycle, shared by both divide phases.
module ng_serial_div
    import ng_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    input  logic             clear,
    input  logic             start,
    input  logic [SQ_W-1:0]  dividend,
    input  logic [LEN_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [SQ_W-1:0]  quotient
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] dvs;
    logic [SQ_W-1:0]  q;
    logic [CNT_W-1:0] cnt;
    logic [LEN_W:0]   shifted;
    logic             take;

    // q holds the remaining dividend bits at the top and collects quotient bits at the bottom
    assign shifted  = {rem, q[SQ_W-1]};
    assign take     = (shifted >= {1'b0, dvs});
    assign quotient = q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rem  <= '0;
            dvs  <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                q    <= dividend;
                rem  <= '0;
                dvs  <= divisor;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                rem <= take ? LEN_W'(shifted - {1'b0, dvs}) : shifted[LEN_W-1:0];
                q   <= {q[SQ_W-2:0], take};
                cnt <= CNT_W'(cnt + 1'b1);
                if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ng_stats_ctrl.sv
// Windowed mean/variance of a signed sample stream; both divisions share one serial divider.
module ng_stats_ctrl
    import ng_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 11,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       result_valid,
    output logic signed [SAMPLE_W-1:0] mean,
    // "var" is a reserved word, hence the longer name
    output logic [2*SAMPLE_W-1:0]      variance
);

    localparam int unsigned VAR_W = 2 * SAMPLE_W;

    state_t                     state, state_n;
    logic [LEN_W-1:0]           len_q, len_n;
    logic [LEN_W-1:0]           cnt, cnt_n;
    logic signed [SUM_W-1:0]    sum, sum_n;
    logic [SQ_W-1:0]            sumsq, sumsq_n;
    logic signed [SAMPLE_W-1:0] mean_q, mean_q_n;
    logic signed [SAMPLE_W-1:0] mean_n;
    logic [VAR_W-1:0]           var_n;
    logic                       busy_n, done_n, err_n, rv_n;

    logic                       div_start_c, div_clear_c;
    logic [SQ_W-1:0]            div_dividend_c;
    logic                       div_busy, div_done;
    logic [SQ_W-1:0]            div_q;

    logic signed [SUM_W-1:0]    sum_add;
    logic signed [SUM_W-1:0]    sum_abs;
    logic signed [VAR_W-1:0]    sq_s;
    logic signed [VAR_W-1:0]    mm_s;
    logic [SAMPLE_W-1:0]        mean_mag;
    logic [LEN_W-1:0]           cnt_inc;

    assign sum_add  = sum + SUM_W'(sample);
    assign sum_abs  = sum_add[SUM_W-1] ? -sum_add : sum_add;
    assign sq_s     = sample * sample;
    assign mm_s     = mean_q * mean_q;
    assign mean_mag = div_q[SAMPLE_W-1:0];
    assign cnt_inc  = LEN_W'(cnt + 1'b1);

    ng_serial_div u_div (
        .clk      (clk),
        .nreset   (nreset),
        .clear    (div_clear_c),
        .start    (div_start_c),
        .dividend (div_dividend_c),
        .divisor  (len_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            len_q        <= '0;
            cnt          <= '0;
            sum          <= '0;
            sumsq        <= '0;
            mean_q       <= '0;
            mean         <= '0;
            variance     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            len_q        <= len_n;
            cnt          <= cnt_n;
            sum          <= sum_n;
            sumsq        <= sumsq_n;
            mean_q       <= mean_q_n;
            mean         <= mean_n;
            variance     <= var_n;
            busy         <= busy_n;
            done         <= done_n;
            err          <= err_n;
            result_valid <= rv_n;
        end
    end

    always_comb begin
        state_n        = state;
        len_n          = len_q;
        cnt_n          = cnt;
        sum_n          = sum;
        sumsq_n        = sumsq;
        mean_q_n       = mean_q;
        mean_n         = mean;
        var_n          = variance;
        busy_n         = busy;
        done_n         = 1'b0;
        err_n          = 1'b0;
        rv_n           = result_valid;
        div_start_c    = 1'b0;
        div_clear_c    = 1'b0;
        div_dividend_c = sumsq;

        if (abort && (state != IDLE)) begin
            state_n     = IDLE;
            busy_n      = 1'b0;
            rv_n        = 1'b0;
            div_clear_c = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort && !busy) begin
                        if (cfg_len == '0) begin
                            err_n = 1'b1;
                        end else begin
                            sum_n   = '0;
                            sumsq_n = '0;
                            len_n   = cfg_len;
                            cnt_n   = '0;
                            rv_n    = 1'b0;
                            busy_n  = 1'b1;
                            state_n = ACC;
                        end
                    end
                end
                ACC: begin
                    if (sample_valid) begin
                        sum_n   = sum_add;
                        sumsq_n = sumsq + SQ_W'($unsigned(sq_s));
                        cnt_n   = cnt_inc;
                        // launch the mean division on the edge that takes the last sample
                        if (cnt_inc == len_q) begin
                            div_start_c    = 1'b1;
                            div_dividend_c = SQ_W'($unsigned(sum_abs));
                            state_n        = DIV_MEAN;
                        end
                    end
                end
                DIV_MEAN: begin
                    if (div_done && !div_busy) begin
                        mean_q_n       = sum[SUM_W-1] ? -$signed(mean_mag) : $signed(mean_mag);
                        div_start_c    = 1'b1;
                        div_dividend_c = sumsq;
                        state_n        = DIV_SQ;
                    end
                end
                DIV_SQ: begin
                    if (div_done) begin
                        if (div_q < SQ_W'($unsigned(mm_s))) begin
                            var_n = '0;
                        end else begin
                            var_n = VAR_W'(div_q - SQ_W'($unsigned(mm_s)));
                        end
                        mean_n  = mean_q;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        rv_n    = 1'b1;
                        state_n = FINISH;
                    end
                end
                FINISH: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ng_stats_ctrl.sv
// Scoreboard bench for ng_stats_ctrl: stimulus queues expected results, monitor checks each done.
module tb_ng_stats_ctrl;

    localparam int SW = 11;
    localparam int LW = 16;

    logic                 clk = 1'b0;
    logic                 nreset = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [LW-1:0]        cfg_len = '0;
    logic                 sample_valid = 1'b0;
    logic signed [SW-1:0] sample = '0;
    logic                 busy, done, err, result_valid;
    logic signed [SW-1:0] mean;
    logic [2*SW-1:0]      variance;

    typedef struct {
        logic signed [SW-1:0] mean;
        logic [2*SW-1:0]      variance;
        int                   acc_cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   ndone = 0;
    int   cyc = 0;
    int   p;

    ng_stats_ctrl #(.SAMPLE_W(SW), .LEN_W(LW)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .start        (start),
        .abort        (abort),
        .cfg_len      (cfg_len),
        .sample_valid (sample_valid),
        .sample       (sample),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .result_valid (result_valid),
        .mean         (mean),
        .variance     (variance)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (nreset && done) begin
            ndone++;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("mean", mean, mon_e.mean);
                check("var", variance, mon_e.variance);
                check("latency", cyc - mon_e.acc_cyc, 78);
                check("rv_at_done", result_valid, 1);
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        cfg_len = LW'(len);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic send(input int s, input int gap, input bit last, input int em, input int ev);
        exp_t e;
        sample       = SW'(s);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        sample       = SW'(0);
        if (last) begin
            e.mean     = SW'(em);
            e.variance = (2*SW)'(ev);
            e.acc_cyc  = cyc;
            sbq.push_back(e);
        end
        repeat (gap) tick();
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (ndone == prev && n < 400) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (ndone == prev) begin
            fails++;
            $display("FAIL done_timeout: got no done expected one within 400 cycles");
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rv"}, result_valid, 0);
        check({tag, "_mean"}, mean, 0);
        check({tag, "_var"}, variance, 0);
    endtask

    initial begin
        #12;
        check_zero("reset");
        nreset = 1'b1;
        tick();

        // len=4, 1..4 -> mean 2, var 3
        p = ndone;
        do_start(4);
        check("busy_after_start", busy, 1);
        check("rv_cleared", result_valid, 0);
        send(1, 0, 0, 0, 0);
        send(2, 0, 0, 0, 0);
        send(3, 0, 0, 0, 0);
        send(4, 0, 1, 2, 3);
        wait_done(p);
        tick();
        check("done_one_cycle", done, 0);
        check("rv_hold", result_valid, 1);
        check("mean_hold", mean, 2);

        // len=3 with gaps, -5,-5,-6 -> mean -5, var 3
        p = ndone;
        do_start(3);
        send(-5, 2, 0, 0, 0);
        send(-5, 1, 0, 0, 0);
        send(-6, 0, 1, -5, 3);
        wait_done(p);
        tick();

        // len=1, most negative sample
        p = ndone;
        do_start(1);
        send(-1024, 0, 1, -1024, 0);
        wait_done(p);
        tick();

        // len=0 rejected
        cfg_len = '0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_rv_kept", result_valid, 1);
        check("err_mean_kept", mean, -1024);
        tick();
        check("err_one_cycle", err, 0);

        // abort and start together in IDLE: abort wins
        cfg_len = LW'(5);
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start   = 1'b0;
        abort   = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_err", err, 0);

        // abort after 2 of 5, then len=2, 7,9 -> mean 8, var 1
        do_start(5);
        send(100, 0, 0, 0, 0);
        send(200, 0, 0, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rv", result_valid, 0);
        check("abort_mean_kept", mean, -1024);
        check("abort_var_kept", variance, 0);
        repeat (100) tick();
        p = ndone;
        do_start(2);
        send(7, 0, 0, 0, 0);
        send(9, 0, 1, 8, 1);
        wait_done(p);
        tick();

        // start pulses while dividing are ignored
        p = ndone;
        do_start(2);
        send(3, 0, 0, 0, 0);
        send(5, 0, 1, 4, 1);
        repeat (3) begin
            cfg_len = LW'(3);
            start   = 1'b1;
            tick();
            start   = 1'b0;
            check("busy_start_no_err", err, 0);
            check("busy_start_busy", busy, 1);
            tick();
        end
        wait_done(p);
        repeat (100) tick();
        check("single_done", ndone, p + 1);
        check("scoreboard_empty", sbq.size(), 0);

        // reset mid-window: immediate zeros, no done afterwards
        p = ndone;
        do_start(4);
        send(10, 0, 0, 0, 0);
        send(20, 0, 0, 0, 0);
        #2;
        nreset = 1'b0;
        #1;
        check_zero("midreset");
        tick();
        nreset = 1'b1;
        repeat (120) tick();
        check("no_done_after_reset", ndone, p);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
